// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use scoreboard, MDU stall, redirect flush.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic              ex_valid,
    input  logic              ex_memrd,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic              redirect_ex,
    input  logic              mdu_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        stall_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  ld_stall_cnt,
    output logic [CNT_W-1:0]  mdu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // With LOAD_LAT=1 a single entry is kept that never becomes valid.
    localparam int SB_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic SB_EN = (LOAD_LAT > 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_LD  = 2'd1,
        STALL_MDU = 2'd2,
        FLUSH     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              sb_vld_q  [SB_N];
    logic              sb_vld_d  [SB_N];
    logic [REG_AW-1:0] sb_addr_q [SB_N];
    logic [REG_AW-1:0] sb_addr_d [SB_N];

    logic ex_load;
    logic rs_hit;
    logic rt_hit;
    logic rs_match;
    logic rt_match;
    logic ld_haz;
    logic sel_flush;
    logic sel_ld;
    logic sel_mdu;

    always_comb begin
        ex_load = ex_valid & ex_memrd;

        rs_hit = ex_load && (ex_wr_addr == rs_id);
        rt_hit = ex_load && (ex_wr_addr == rt_id);
        for (int i = 0; i < SB_N; i++) begin
            rs_hit = rs_hit | (sb_vld_q[i] && (sb_addr_q[i] == rs_id));
            rt_hit = rt_hit | (sb_vld_q[i] && (sb_addr_q[i] == rt_id));
        end
        rs_match = rs_used_id && (rs_id != '0) && rs_hit;
        rt_match = rt_used_id && (rt_id != '0) && rt_hit;
        ld_haz   = rs_match | rt_match;

        sel_flush = redirect_ex;
        sel_ld    = !redirect_ex && ld_haz;
        sel_mdu   = !redirect_ex && !ld_haz && mdu_busy;

        // Scoreboard shifts every cycle, independent of stall or flush.
        sb_vld_d[0]  = SB_EN && ex_load && (ex_wr_addr != '0);
        sb_addr_d[0] = ex_wr_addr;
        for (int i = 1; i < SB_N; i++) begin
            sb_vld_d[i]  = sb_vld_q[i-1];
            sb_addr_d[i] = sb_addr_q[i-1];
        end

        if (sel_flush) begin
            state_d = FLUSH;
        end else if (sel_ld) begin
            state_d = STALL_LD;
        end else if (sel_mdu) begin
            state_d = STALL_MDU;
        end else begin
            state_d = RUN;
        end

        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!rst) begin
            if (sel_flush) begin
                idex_bubble = 1'b1;
                ifid_flush  = 1'b1;
            end else if (sel_ld || sel_mdu) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            for (int i = 0; i < SB_N; i++) begin
                sb_vld_q[i]  <= 1'b0;
                sb_addr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < SB_N; i++) begin
                sb_vld_q[i]  <= sb_vld_d[i];
                sb_addr_q[i] <= sb_addr_d[i];
            end
        end
    end

    assign stall_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;
    logic [CNT_W-1:0] mdu_stall_cnt_q, mdu_stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; they hold at all-ones rather than wrapping.
    always_comb begin
        ld_stall_cnt_d  = ld_stall_cnt_q;
        mdu_stall_cnt_d = mdu_stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (sel_ld && (ld_stall_cnt_q != '1)) begin
            ld_stall_cnt_d = ld_stall_cnt_q + 1'b1;
        end
        if (sel_mdu && (mdu_stall_cnt_q != '1)) begin
            mdu_stall_cnt_d = mdu_stall_cnt_q + 1'b1;
        end
        if (sel_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_stall_cnt_q  <= '0;
            mdu_stall_cnt_q <= '0;
            flush_cnt_q     <= '0;
        end else begin
            ld_stall_cnt_q  <= ld_stall_cnt_d;
            mdu_stall_cnt_q <= mdu_stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign ld_stall_cnt  = ld_stall_cnt_q;
    assign mdu_stall_cnt = mdu_stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_hazard_ctrl_unit;

    localparam logic [3:0] PASS_V  = 4'b1100;
    localparam logic [3:0] STALL_V = 4'b0010;
    localparam logic [3:0] FLUSH_V = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_id = '0, rt_id = '0, ex_wr_addr = '0;
    logic       rs_used_id = 0, rt_used_id = 0, ex_valid = 0, ex_memrd = 0;
    logic       redirect_ex = 0, mdu_busy = 0;

    logic       o1_pc_we, o1_ifid_we, o1_idex_bubble, o1_ifid_flush;
    logic       o3_pc_we, o3_ifid_we, o3_idex_bubble, o3_ifid_flush;
    logic [1:0] o1_state, o3_state;
    logic [3:0] o1_v, o3_v;

    int n_pass  = 0;
    int n_total = 0;

    assign o1_v = {o1_pc_we, o1_ifid_we, o1_idex_bubble, o1_ifid_flush};
    assign o3_v = {o3_pc_we, o3_ifid_we, o3_idex_bubble, o3_ifid_flush};

    always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] c1_ld, c1_mdu, c1_fl, c3_ld, c3_mdu, c3_fl;
`endif

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_wr_addr(ex_wr_addr),
        .redirect_ex(redirect_ex), .mdu_busy(mdu_busy),
        .pc_we(o1_pc_we), .ifid_we(o1_ifid_we), .idex_bubble(o1_idex_bubble),
        .ifid_flush(o1_ifid_flush), .stall_state(o1_state)
`ifdef HAZ_PERF_CNT_EN
        , .ld_stall_cnt(c1_ld), .mdu_stall_cnt(c1_mdu), .flush_cnt(c1_fl)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u3 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_wr_addr(ex_wr_addr),
        .redirect_ex(redirect_ex), .mdu_busy(mdu_busy),
        .pc_we(o3_pc_we), .ifid_we(o3_ifid_we), .idex_bubble(o3_idex_bubble),
        .ifid_flush(o3_ifid_flush), .stall_state(o3_state)
`ifdef HAZ_PERF_CNT_EN
        , .ld_stall_cnt(c3_ld), .mdu_stall_cnt(c3_mdu), .flush_cnt(c3_fl)
`endif
    );

    task automatic set_in(input logic ev, input logic em, input logic [4:0] wa,
                          input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu,
                          input logic rd, input logic md);
        ex_valid = ev; ex_memrd = em; ex_wr_addr = wa;
        rs_id = rs; rs_used_id = rsu; rt_id = rt; rt_used_id = rtu;
        redirect_ex = rd; mdu_busy = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        set_in(1, 1, 5'd5, 5'd5, 1, 5'd5, 1, 0, 1);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL reset_out3 got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        n_total++;
        if (o1_v !== PASS_V) $display("FAIL reset_out1 got %b exp %b", o1_v, PASS_V);
        else n_pass++;
        tick();
        n_total++;
        if (o3_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", o3_state);
        else n_pass++;
        idle(1);
        rst = 1'b0;
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL reset_release got %b exp %b", o3_v, PASS_V);
        else n_pass++;
    endtask

    task automatic test_ll1();
        set_in(1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
        #1;
        n_total++;
        if (o1_v !== STALL_V) $display("FAIL ll1_stall got %b exp %b", o1_v, STALL_V);
        else n_pass++;
        tick();
        set_in(0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0);
        #1;
        n_total++;
        if (o1_v !== PASS_V) $display("FAIL ll1_release got %b exp %b", o1_v, PASS_V);
        else n_pass++;
        n_total++;
        if (o1_state !== 2'd1) $display("FAIL ll1_state got %0d exp 1", o1_state);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_ll3_direct();
        int stalls = 0;
        logic done = 0;
        logic [1:0] st1 = 2'd0;
        set_in(1, 1, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0);
        for (int c = 0; c < 8 && !done; c++) begin
            #1;
            if (c == 1) st1 = o3_state;
            if (o3_v === STALL_V) stalls++;
            else done = 1;
            tick();
            set_in(0, 0, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0);
        end
        n_total++;
        if (stalls != 3) $display("FAIL ll3_direct_len got %0d exp 3", stalls);
        else n_pass++;
        n_total++;
        if (st1 !== 2'd1) $display("FAIL ll3_state got %0d exp 1", st1);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_ll3_gap();
        int stalls = 0;
        logic done = 0;
        set_in(1, 1, 5'd7, 5'd0, 0, 5'd3, 1, 0, 0);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL gap_indep got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        tick();
        set_in(1, 0, 5'd3, 5'd0, 0, 5'd7, 1, 0, 0);
        for (int c = 0; c < 8 && !done; c++) begin
            #1;
            if (o3_v === STALL_V) stalls++;
            else done = 1;
            tick();
            set_in(0, 0, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0);
        end
        n_total++;
        if (stalls != 2) $display("FAIL gap1_len got %0d exp 2", stalls);
        else n_pass++;
        idle(3);
        // Three independent instructions between: the load has retired.
        set_in(1, 1, 5'd7, 5'd0, 0, 5'd2, 1, 0, 0);
        tick();
        set_in(1, 0, 5'd2, 5'd0, 0, 5'd1, 1, 0, 0);
        tick();
        set_in(1, 0, 5'd1, 5'd0, 0, 5'd4, 1, 0, 0);
        tick();
        set_in(1, 0, 5'd4, 5'd0, 0, 5'd7, 1, 0, 0);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL gap3_nostall got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_zero_unused();
        set_in(1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL r0_ex got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        tick();
        set_in(0, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL r0_sb got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        set_in(1, 1, 5'd9, 5'd9, 0, 5'd0, 0, 0, 0);
        #1;
        n_total++;
        if (o1_v !== PASS_V) $display("FAIL unused1 got %b exp %b", o1_v, PASS_V);
        else n_pass++;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL unused3 got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_priority();
        set_in(1, 1, 5'd4, 5'd4, 1, 5'd0, 0, 1, 1);
        #1;
        n_total++;
        if (o3_v !== FLUSH_V) $display("FAIL prio_out3 got %b exp %b", o3_v, FLUSH_V);
        else n_pass++;
        n_total++;
        if (o1_v !== FLUSH_V) $display("FAIL prio_out1 got %b exp %b", o1_v, FLUSH_V);
        else n_pass++;
        tick();
        n_total++;
        if (o3_state !== 2'd3) $display("FAIL prio_state got %0d exp 3", o3_state);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_mdu();
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
            #1;
            n_total++;
            if (o3_v !== STALL_V) $display("FAIL mdu_out c%0d got %b exp %b", c, o3_v, STALL_V);
            else n_pass++;
            if (c > 0) begin
                n_total++;
                if (o3_state !== 2'd2) $display("FAIL mdu_state c%0d got %0d exp 2", c, o3_state);
                else n_pass++;
            end
            tick();
        end
        set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL mdu_done got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        tick();
        n_total++;
        if (o3_state !== 2'd0) $display("FAIL mdu_run got %0d exp 0", o3_state);
        else n_pass++;
`ifdef HAZ_PERF_CNT_EN
        n_total++;
        if (c3_mdu !== 32'd4) $display("FAIL mdu_cnt got %0d exp 4", c3_mdu);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        set_in(1, 1, 5'd7, 5'd7, 1, 5'd0, 0, 0, 0);
        #1;
        n_total++;
        if (o3_v !== STALL_V) $display("FAIL rstmid_pre got %b exp %b", o3_v, STALL_V);
        else n_pass++;
        tick();
        set_in(0, 0, 5'd0, 5'd7, 1, 5'd0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL rstmid_out got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        n_total++;
        if (o3_state !== 2'd0) $display("FAIL rstmid_state got %0d exp 0", o3_state);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (o3_v !== PASS_V) $display("FAIL rstmid_after got %b exp %b", o3_v, PASS_V);
        else n_pass++;
        tick();
        n_total++;
        if (o3_state !== 2'd0) $display("FAIL rstmid_run got %0d exp 0", o3_state);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ll1();
        test_ll3_direct();
        test_ll3_gap();
        test_zero_unused();
        test_priority();
        test_mdu();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
